// File: rtl/arb_mux_n_if.sv
// rtl/arb_mux_n_if.sv - channel, output and control bundle for the N-way arbitrating mux
interface arb_mux_n_if #(
  parameter int WIDTH = 32,
  parameter int NCH   = 8,
  parameter int SEL_W = 3
);
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic                 mode;
  logic                 force_en;
  logic [SEL_W-1:0]     force_sel;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [SEL_W-1:0]     out_ch;
  logic [15:0]          xfer_cnt;

  modport slave (
    input  in_data, in_valid, mode, force_en, force_sel, out_ready,
    output in_ready, out_data, out_valid, out_ch, xfer_cnt
  );

  modport master (
    output in_data, in_valid, mode, force_en, force_sel, out_ready,
    input  in_ready, out_data, out_valid, out_ch, xfer_cnt
  );
endinterface

// File: rtl/arb_mux_n.sv
// rtl/arb_mux_n.sv - N-channel arbiter (round-robin / fixed / forced) feeding a one-word output slot
module arb_mux_n #(
  parameter int WIDTH = 32,
  parameter int NCH   = 8,
  parameter int SEL_W = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  arb_mux_n_if.slave bus
);
  logic [NCH-1:0]   eligible;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] grant_idx;
  logic             grant_found;
  logic [SEL_W:0]   cand;
  logic             acc;
  logic             xfer;

  // Forcing a channel outside 0..NCH-1 leaves nothing eligible.
  always_comb begin
    eligible = bus.in_valid;
    if (bus.force_en) begin
      eligible = '0;
      if ({1'b0, bus.force_sel} < (SEL_W+1)'(NCH))
        eligible[bus.force_sel] = bus.in_valid[bus.force_sel];
    end
  end

  // Fixed priority scans from 0; round-robin scans upward from rr_ptr with wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NCH; k++) begin
      if (bus.mode) begin
        cand = (SEL_W+1)'(k);
      end else begin
        cand = {1'b0, rr_ptr} + (SEL_W+1)'(k);
        if (cand >= (SEL_W+1)'(NCH))
          cand = cand - (SEL_W+1)'(NCH);
      end
      if (!grant_found && eligible[cand[SEL_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[SEL_W-1:0];
      end
    end
  end

  assign acc          = !bus.out_valid || bus.out_ready;
  assign xfer         = rst_n && acc && grant_found;
  assign bus.in_ready = xfer ? (NCH'(1) << grant_idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
      rr_ptr        <= '0;
      bus.xfer_cnt  <= '0;
    end else if (xfer) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= bus.in_data[grant_idx*WIDTH +: WIDTH];
      bus.out_ch    <= grant_idx;
      rr_ptr        <= (grant_idx == SEL_W'(NCH-1)) ? '0 : grant_idx + SEL_W'(1);
      bus.xfer_cnt  <= bus.xfer_cnt + 16'd1;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_arb_mux_n.sv
// tb/tb_arb_mux_n.sv - scoreboard bench for arb_mux_n
module tb_arb_mux_n;
  localparam int WIDTH = 32;
  localparam int NCH   = 8;
  localparam int SEL_W = 3;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  ch;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  arb_mux_n_if #(.WIDTH(WIDTH), .NCH(NCH), .SEL_W(SEL_W)) bus ();
  arb_mux_n #(.WIDTH(WIDTH), .NCH(NCH), .SEL_W(SEL_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  exp_t        sb[$];
  logic [31:0] chd[NCH];
  int          total = 0;
  int          bad = 0;
  int          m_rr = 0;
  int          m_cnt = 0;
  logic        m_valid = 1'b0;
  logic [7:0]  exp_ready;

  function automatic int predict(logic [7:0] v, logic md, logic fe, logic [2:0] fs, int rr);
    logic [7:0] e;
    int idx;
    e = fe ? (v & (8'b1 << fs)) : v;
    for (int k = 0; k < NCH; k++) begin
      idx = md ? k : (rr + k) % NCH;
      if (e[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_rr = 0;
    m_cnt = 0;
    m_valid = 1'b0;
    sb.delete();
  endtask

  task automatic apply(input logic [7:0] v, input logic md, input logic fe, input logic [2:0] fs, input logic ordy);
    int g;
    exp_t e;
    for (int i = 0; i < NCH; i++) bus.in_data[i*WIDTH +: WIDTH] = chd[i];
    bus.in_valid  = v;
    bus.mode      = md;
    bus.force_en  = fe;
    bus.force_sel = fs;
    bus.out_ready = ordy;
    g = predict(v, md, fe, fs, m_rr);
    exp_ready = '0;
    if ((!m_valid || ordy) && g >= 0) begin
      e.data = chd[g];
      e.ch   = 3'(g);
      sb.push_back(e);
      exp_ready = 8'(1) << g;
      m_rr = (g + 1) % NCH;
      m_cnt = (m_cnt + 1) & 'hFFFF;
      m_valid = 1'b1;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic pop_exp(output exp_t e, output bit ok);
    ok = (sb.size() != 0);
    e = '0;
    if (ok) e = sb.pop_front();
  endtask

  task automatic test_reset();
    for (int i = 0; i < NCH; i++) chd[i] = 32'h5A00_0000 + i;
    apply(8'hFF, 1'b0, 1'b0, 3'd0, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.out_data !== 32'h0) begin bad++; $display("FAIL rst_data got=%h want=0", bus.out_data); end
    total++; if (bus.out_ch !== 3'd0) begin bad++; $display("FAIL rst_ch got=%0d want=0", bus.out_ch); end
    total++; if (bus.xfer_cnt !== 16'h0) begin bad++; $display("FAIL rst_cnt got=%h want=0", bus.xfer_cnt); end
    total++; if (bus.in_ready !== 8'h0) begin bad++; $display("FAIL rst_ready got=%b want=0", bus.in_ready); end
    step();
    step();
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 8'h0) begin bad++; $display("FAIL rst_held got=%b/%b want=0/0", bus.out_valid, bus.in_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    exp_t e;
    bit ok;
    for (int i = 0; i < NCH; i++) chd[i] = 32'h1000_0000 + 32'(i * 32'h111);
    for (int k = 0; k < 16; k++) begin
      apply(8'hFF, 1'b0, 1'b0, 3'd0, 1'b1);
      total++; if (bus.in_ready !== exp_ready) begin bad++; $display("FAIL rr_ready%0d got=%b want=%b", k, bus.in_ready, exp_ready); end
      step();
      pop_exp(e, ok);
      total++; if (!ok || bus.out_data !== e.data || bus.out_valid !== 1'b1) begin bad++; $display("FAIL rr_data%0d got=%h want=%h", k, bus.out_data, e.data); end
      total++; if (bus.out_ch !== 3'(k % 8)) begin bad++; $display("FAIL rr_ch%0d got=%0d want=%0d", k, bus.out_ch, k % 8); end
    end
    total++; if (bus.xfer_cnt !== 16'd16) begin bad++; $display("FAIL rr_cnt got=%0d want=16", bus.xfer_cnt); end
  endtask

  task automatic test_force();
    exp_t e;
    bit ok;
    chd = '{32'h00000045, 32'hAB000002, 32'h00C45008, 32'h00000002,
            32'hAACDFF23, 32'h00000002, 32'h00F00002, 32'h00CF0002};
    for (int s = 0; s < NCH; s++) begin
      apply(8'hFF, s[0], 1'b1, 3'(s), 1'b1);
      total++; if (bus.in_ready !== (8'(1) << s)) begin bad++; $display("FAIL force_ready%0d got=%b", s, bus.in_ready); end
      step();
      pop_exp(e, ok);
      total++; if (!ok || bus.out_data !== e.data) begin bad++; $display("FAIL force_data%0d got=%h want=%h", s, bus.out_data, e.data); end
      total++; if (bus.out_ch !== 3'(s)) begin bad++; $display("FAIL force_ch%0d got=%0d want=%0d", s, bus.out_ch, s); end
    end
    apply(8'b1111_0111, 1'b0, 1'b1, 3'd3, 1'b1);
    total++; if (bus.in_ready !== 8'h0) begin bad++; $display("FAIL force_idle_ready got=%b want=0", bus.in_ready); end
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL force_idle_valid got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_priority();
    exp_t e;
    bit ok;
    for (int i = 0; i < NCH; i++) chd[i] = 32'h2000_0000 + i;
    for (int k = 0; k < 6; k++) begin
      apply(8'b1010_0100, 1'b1, 1'b0, 3'd0, 1'b1);
      total++; if (bus.in_ready !== 8'b0000_0100) begin bad++; $display("FAIL prio_ready%0d got=%b want=00000100", k, bus.in_ready); end
      step();
      pop_exp(e, ok);
      total++; if (!ok || bus.out_ch !== 3'd2 || bus.out_data !== e.data) begin bad++; $display("FAIL prio_ch%0d got=%0d want=2", k, bus.out_ch); end
    end
    apply(8'b1010_0000, 1'b1, 1'b0, 3'd0, 1'b1);
    step();
    pop_exp(e, ok);
    total++; if (!ok || bus.out_ch !== 3'd5) begin bad++; $display("FAIL prio_next got=%0d want=5", bus.out_ch); end
  endtask

  task automatic test_backpressure();
    exp_t e;
    bit ok;
    logic [15:0] held_cnt;
    chd[3] = 32'hFFF00045;
    chd[4] = 32'hCAFE0004;
    apply(8'b0000_1000, 1'b1, 1'b0, 3'd0, 1'b1);
    step();
    pop_exp(e, ok);
    total++; if (!ok || bus.out_data !== 32'hFFF00045) begin bad++; $display("FAIL bp_load got=%h want=fff00045", bus.out_data); end
    held_cnt = 16'(m_cnt);
    for (int k = 0; k < 5; k++) begin
      apply(8'hFF, 1'b0, 1'b0, 3'd0, 1'b0);
      total++; if (bus.in_ready !== 8'h0) begin bad++; $display("FAIL bp_ready%0d got=%b want=0", k, bus.in_ready); end
      step();
      total++; if (bus.out_data !== 32'hFFF00045 || bus.out_valid !== 1'b1 || bus.out_ch !== 3'd3) begin bad++; $display("FAIL bp_hold%0d got=%h want=fff00045", k, bus.out_data); end
      total++; if (bus.xfer_cnt !== held_cnt) begin bad++; $display("FAIL bp_cnt%0d got=%h want=%h", k, bus.xfer_cnt, held_cnt); end
    end
    apply(8'b0001_0000, 1'b0, 1'b0, 3'd0, 1'b1);
    total++; if (bus.in_ready !== 8'b0001_0000) begin bad++; $display("FAIL bp_release_ready got=%b want=00010000", bus.in_ready); end
    step();
    pop_exp(e, ok);
    total++; if (!ok || bus.out_data !== e.data || bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_release got=%h want=cafe0004", bus.out_data); end
    apply(8'h00, 1'b0, 1'b0, 3'd0, 1'b1);
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_async_reset();
    exp_t e;
    bit ok;
    for (int i = 0; i < NCH; i++) chd[i] = 32'h3000_0000 + i;
    for (int k = 0; k < 3; k++) begin
      apply(8'hFF, 1'b0, 1'b0, 3'd0, 1'b1);
      step();
      pop_exp(e, ok);
    end
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL ar_pre got=%b want=1", bus.out_valid); end
    rst_n = 1'b0;
    #1;
    model_reset();
    total++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin bad++; $display("FAIL ar_out got=%b/%h want=0/0", bus.out_valid, bus.out_data); end
    total++; if (bus.xfer_cnt !== 16'h0 || bus.in_ready !== 8'h0) begin bad++; $display("FAIL ar_cnt got=%h/%b want=0/0", bus.xfer_cnt, bus.in_ready); end
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      apply(8'hFF, 1'b0, 1'b0, 3'd0, 1'b1);
      step();
      pop_exp(e, ok);
      total++; if (!ok || bus.out_ch !== 3'(k) || bus.out_data !== e.data) begin bad++; $display("FAIL ar_rr%0d got=%0d want=%0d", k, bus.out_ch, k); end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    bit ok;
    logic [15:0] want[3];
    want = '{16'hFFFF, 16'h0000, 16'h0001};
    while (m_cnt != 'hFFFE) begin
      apply(8'hFF, 1'b0, 1'b0, 3'd0, 1'b1);
      step();
      pop_exp(e, ok);
    end
    total++; if (bus.xfer_cnt !== 16'hFFFE) begin bad++; $display("FAIL wrap_pre got=%h want=fffe", bus.xfer_cnt); end
    for (int k = 0; k < 3; k++) begin
      apply(8'hFF, 1'b0, 1'b0, 3'd0, 1'b1);
      step();
      pop_exp(e, ok);
      total++; if (!ok || bus.xfer_cnt !== want[k]) begin bad++; $display("FAIL wrap%0d got=%h want=%h", k, bus.xfer_cnt, want[k]); end
    end
  endtask

  initial begin
    bus.in_data   = '0;
    bus.in_valid  = '0;
    bus.mode      = 1'b0;
    bus.force_en  = 1'b0;
    bus.force_sel = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_round_robin();
    test_force();
    test_priority();
    test_backpressure();
    test_async_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
